ventana_deslizante_param: RTL and testbench



---
 rtl/ventana_pkg.sv | 22 ++
 rtl/linea_buffer.sv | 54 +++++
 rtl/ventana_deslizante_param.sv | 228 ++++++++++++++++++++++
 tb/tb_ventana_deslizante_param.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ventana_pkg.sv
// Shared types and constants for the parametrised sliding-window generator.
// Optional coordinate outputs are enabled in the top by VENTANA_COORDENADAS_EN.
package ventana_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LLENADO = 2'd1,
        ACTIVO  = 2'd2,
        DRENAJE = 2'd3
    } estado_t;

    localparam int MASCARA_MAX       = 5;
    localparam int MASCARA_3         = 3;
    localparam int MASCARA_5         = 5;
    localparam int VENTANA_ELEMENTOS = 25;

    // Flat-bus element index of a window position, row-major on a 5x5 grid.
    function automatic logic [4:0] idx_ventana(input int fila, input int col);
        return 5'(fila * MASCARA_MAX + col);
    endfunction

endpackage

// File: rtl/linea_buffer.sv
// Circular line buffer: read-before-write RAM giving an exact ancho_i-sample delay.
// Part of ventana_deslizante_param (optional macro VENTANA_COORDENADAS_EN not used here).
module linea_buffer #(
    parameter int BITS_PIXEL = 8,
    parameter int MAX_ANCHO  = 1024,
    parameter int BITS_DIM   = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  limpiar_i,
    input  logic                  en_i,
    input  logic [BITS_DIM-1:0]   ancho_i,
    input  logic [BITS_PIXEL-1:0] dato_i,
    output logic [BITS_PIXEL-1:0] dato_o
);

    localparam int AW = (MAX_ANCHO > 1) ? $clog2(MAX_ANCHO) : 1;

    logic [BITS_PIXEL-1:0] mem_q [MAX_ANCHO];
    logic [AW-1:0]         ptr_q;
    logic [AW-1:0]         ptr_d;

    // The slot about to be overwritten holds the sample from ancho_i accepts ago.
    assign dato_o = mem_q[ptr_q];

    // Pointer advance, wrapping at the programmed line length.
    always_comb begin
        ptr_d = ptr_q;
        if (limpiar_i) begin
            ptr_d = '0;
        end else if (en_i) begin
            ptr_d = (BITS_DIM'(ptr_q) == ancho_i - BITS_DIM'(1)) ? '0 : ptr_q + AW'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Storage write; contents need no reset.
    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[ptr_q] <= dato_i;
        end
    end

endmodule

// File: rtl/ventana_deslizante_param.sv
// Sliding 3x3/5x5 window generator over a raster pixel stream with ready/valid on both sides.
// Define VENTANA_COORDENADAS_EN to add the centro_fila/centro_columna outputs.
module ventana_deslizante_param
    import ventana_pkg::*;
#(
    parameter int BITS_PIXEL   = 8,
    parameter int MAX_ANCHO    = 1024,
    parameter int BITS_DIM     = 11,
    parameter int BITS_MASCARA = 3
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      iniciar,
    input  logic [BITS_DIM-1:0]                       ancho_imagen,
    input  logic [BITS_DIM-1:0]                       alto_imagen,
    input  logic [BITS_MASCARA-1:0]                   tamano_mascara,
    input  logic [BITS_PIXEL-1:0]                     pixel_entrada,
    input  logic                                      pixel_valido,
    output logic                                      read_pixel,
    output logic [VENTANA_ELEMENTOS*BITS_PIXEL-1:0]   ventana,
    output logic                                      ventana_valida,
    input  logic                                      siguiente_ventana,
`ifdef VENTANA_COORDENADAS_EN
    output logic [BITS_DIM-1:0]                       centro_fila,
    output logic [BITS_DIM-1:0]                       centro_columna,
`endif
    output logic                                      fin_imagen,
    output logic                                      error_config
);

    estado_t estado_q, estado_d;
    logic [BITS_DIM-1:0]     ancho_q, ancho_d, alto_q, alto_d;
    logic [BITS_DIM-1:0]     fila_q, fila_d, col_q, col_d;
    logic [BITS_MASCARA-1:0] m_q, m_d;
    logic [VENTANA_ELEMENTOS-1:0][BITS_PIXEL-1:0] win_q, win_d;
    logic valida_q, valida_d, fin_q, fin_d, err_q, err_d;
    logic acepta_s, califica_s, ultimo_s, config_ok_s;
    logic [BITS_DIM-1:0]   m_menos1_s;
    logic [BITS_PIXEL-1:0] cadena_s [5];
    logic [BITS_PIXEL-1:0] col_nueva_s [MASCARA_MAX];
    int                    m_int_s;

    assign m_menos1_s  = BITS_DIM'(m_q) - BITS_DIM'(1);
    assign m_int_s     = int'(m_q);
    assign config_ok_s = ((tamano_mascara == BITS_MASCARA'(MASCARA_3)) ||
                          (tamano_mascara == BITS_MASCARA'(MASCARA_5))) &&
                         (ancho_imagen >= BITS_DIM'(tamano_mascara)) &&
                         (alto_imagen  >= BITS_DIM'(tamano_mascara)) &&
                         (ancho_imagen <= BITS_DIM'(MAX_ANCHO));

    assign read_pixel = ((estado_q == LLENADO) || (estado_q == ACTIVO)) &&
                        !(valida_q && !siguiente_ventana);
    assign acepta_s   = pixel_valido && read_pixel;
    assign califica_s = acepta_s && (fila_q >= m_menos1_s) && (col_q >= m_menos1_s);
    assign ultimo_s   = acepta_s && (fila_q == alto_q - BITS_DIM'(1)) &&
                        (col_q == ancho_q - BITS_DIM'(1));

    // Chain: buffer i delays the stream by one more line; cadena_s[i+1] is i+1 rows back.
    assign cadena_s[0] = pixel_entrada;
    for (genvar i = 0; i < MASCARA_MAX - 1; i++) begin : g_lb
        linea_buffer #(
            .BITS_PIXEL(BITS_PIXEL),
            .MAX_ANCHO (MAX_ANCHO),
            .BITS_DIM  (BITS_DIM)
        ) u_lb (
            .clk      (clk),
            .reset    (reset),
            .limpiar_i(estado_q == IDLE),
            .en_i     (acepta_s),
            .ancho_i  (ancho_q),
            .dato_i   (cadena_s[i]),
            .dato_o   (cadena_s[i+1])
        );
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= IDLE;
        end else begin
            estado_q <= estado_d;
        end
    end

    // Next-state logic.
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            IDLE:    estado_d = (iniciar && config_ok_s) ? LLENADO : IDLE;
            LLENADO: begin
                if (ultimo_s) begin
                    estado_d = DRENAJE;
                end else if (califica_s) begin
                    estado_d = ACTIVO;
                end else begin
                    estado_d = LLENADO;
                end
            end
            ACTIVO:  estado_d = ultimo_s ? DRENAJE : ACTIVO;
            DRENAJE: estado_d = (!valida_q || siguiente_ventana) ? IDLE : DRENAJE;
            default: estado_d = IDLE;
        endcase
    end

    // Newest column: oldest row takes the longest line-buffer tap, last row the live pixel.
    always_comb begin
        for (int r = 0; r < MASCARA_MAX; r++) begin
            col_nueva_s[r] = '0;
        end
        if (m_q == BITS_MASCARA'(MASCARA_5)) begin
            for (int r = 0; r < MASCARA_5; r++) begin
                col_nueva_s[r] = cadena_s[MASCARA_5 - 1 - r];
            end
        end else begin
            for (int r = 0; r < MASCARA_3; r++) begin
                col_nueva_s[r] = cadena_s[MASCARA_3 - 1 - r];
            end
        end
    end

    // Output and datapath next-state logic.
    always_comb begin
        ancho_d  = ancho_q;
        alto_d   = alto_q;
        m_d      = m_q;
        fila_d   = fila_q;
        col_d    = col_q;
        win_d    = win_q;
        err_d    = (estado_q == IDLE) && iniciar && !config_ok_s;
        fin_d    = (estado_q == DRENAJE) && (!valida_q || siguiente_ventana);
        valida_d = califica_s ? 1'b1 : (siguiente_ventana ? 1'b0 : valida_q);
        if (estado_q == IDLE) begin
            if (iniciar) begin
                ancho_d = ancho_imagen;
                alto_d  = alto_imagen;
                m_d     = tamano_mascara;
            end else begin
                m_d = m_q;
            end
            fila_d = '0;
            col_d  = '0;
        end else if (acepta_s) begin
            if (col_q == ancho_q - BITS_DIM'(1)) begin
                col_d  = '0;
                fila_d = fila_q + BITS_DIM'(1);
            end else begin
                col_d = col_q + BITS_DIM'(1);
            end
        end else begin
            col_d = col_q;
        end
        if (acepta_s) begin
            for (int r = 0; r < MASCARA_MAX; r++) begin
                for (int c = 0; c < MASCARA_MAX; c++) begin
                    if ((r >= m_int_s) || (c >= m_int_s)) begin
                        win_d[idx_ventana(r, c)] = '0;
                    end else if (c == m_int_s - 1) begin
                        win_d[idx_ventana(r, c)] = col_nueva_s[r];
                    end else begin
                        win_d[idx_ventana(r, c)] = win_q[idx_ventana(r, (c < 4) ? c + 1 : c)];
                    end
                end
            end
        end else begin
            win_d = win_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ancho_q  <= '0;
            alto_q   <= '0;
            m_q      <= '0;
            fila_q   <= '0;
            col_q    <= '0;
            win_q    <= '0;
            valida_q <= 1'b0;
            fin_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            ancho_q  <= ancho_d;
            alto_q   <= alto_d;
            m_q      <= m_d;
            fila_q   <= fila_d;
            col_q    <= col_d;
            win_q    <= win_d;
            valida_q <= valida_d;
            fin_q    <= fin_d;
            err_q    <= err_d;
        end
    end

`ifdef VENTANA_COORDENADAS_EN
    logic [BITS_DIM-1:0] cfila_q, cfila_d, ccol_q, ccol_d;

    // Centre coordinates follow the window registers, captured on the qualifying pixel.
    always_comb begin
        if (califica_s) begin
            cfila_d = fila_q - (m_menos1_s >> 1);
            ccol_d  = col_q - (m_menos1_s >> 1);
        end else begin
            cfila_d = cfila_q;
            ccol_d  = ccol_q;
        end
    end

    // Centre coordinate registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cfila_q <= '0;
            ccol_q  <= '0;
        end else begin
            cfila_q <= cfila_d;
            ccol_q  <= ccol_d;
        end
    end

    assign centro_fila    = cfila_q;
    assign centro_columna = ccol_q;
`endif

    assign ventana        = win_q;
    assign ventana_valida = valida_q;
    assign fin_imagen     = fin_q;
    assign error_config   = err_q;

endmodule

// File: tb/tb_ventana_deslizante_param.sv
// Scoreboard bench for ventana_deslizante_param (default build, VENTANA_COORDENADAS_EN undefined).
module tb_ventana_deslizante_param;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         iniciar = 1'b0;
    logic [10:0]  ancho_imagen = 11'd0;
    logic [10:0]  alto_imagen = 11'd0;
    logic [2:0]   tamano_mascara = 3'd0;
    logic [7:0]   pixel_entrada = 8'd0;
    logic         pixel_valido = 1'b0;
    logic         read_pixel;
    logic [199:0] ventana;
    logic         ventana_valida;
    logic         siguiente_ventana = 1'b1;
    logic         fin_imagen;
    logic         error_config;

    int n_cmp = 0;
    int n_err = 0;
    int n_fin = 0;
    int frame_wins = 0;
    bit stall_en = 1'b0;
    logic [199:0] first_win = '0;
    logic [199:0] exp_q [$];

    always #5 clk = ~clk;

    ventana_deslizante_param dut (
        .clk              (clk),
        .reset            (reset),
        .iniciar          (iniciar),
        .ancho_imagen     (ancho_imagen),
        .alto_imagen      (alto_imagen),
        .tamano_mascara   (tamano_mascara),
        .pixel_entrada    (pixel_entrada),
        .pixel_valido     (pixel_valido),
        .read_pixel       (read_pixel),
        .ventana          (ventana),
        .ventana_valida   (ventana_valida),
        .siguiente_ventana(siguiente_ventana),
        .fin_imagen       (fin_imagen),
        .error_config     (error_config)
    );

    task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int pat, input int w, input int f, input int c);
        if (pat == 0) return 8'((f * w + c) & 255);
        else          return 8'((f * 37 + c * 11 + 5) & 255);
    endfunction

    // Window of image positions ending at (f,c); unused 5x5 slots are zero.
    function automatic logic [199:0] ventana_esperada(input int pat, input int w, input int m,
                                                      input int f, input int c);
        logic [199:0] v = '0;
        for (int r = 0; r < 5; r++)
            for (int k = 0; k < 5; k++)
                if (r < m && k < m)
                    v[(r * 5 + k) * 8 +: 8] = pix(pat, w, f - (m - 1) + r, c - (m - 1) + k);
        return v;
    endfunction

    function automatic logic [199:0] elem(input logic [199:0] v, input int k);
        return 200'(v[k * 8 +: 8]);
    endfunction

    // Monitor: every window the consumer takes is popped and compared.
    initial begin
        logic [199:0] e;
        forever begin
            @(negedge clk);
            if (fin_imagen) n_fin++;
            if (ventana_valida) begin
                if (stall_en && frame_wins == 3) begin
                    stall_en = 1'b0;
                    siguiente_ventana = 1'b0;
                    repeat (3) begin
                        @(negedge clk);
                        chk("stall_hold", ventana, (exp_q.size() > 0) ? exp_q[0] : '0);
                        chk("stall_ready", 200'(read_pixel), 200'(0));
                    end
                    siguiente_ventana = 1'b1;
                end
                if (siguiente_ventana) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_window", ventana, 200'(0));
                        if (ventana == 200'(0)) begin
                            n_err++;
                            $display("FAIL unexpected_window: got a window expected none");
                        end
                    end else begin
                        e = exp_q.pop_front();
                        chk("window", ventana, e);
                    end
                    if (frame_wins == 0) first_win = ventana;
                    frame_wins++;
                end
            end
        end
    end

    task automatic run_frame(input int w, input int h, input int m, input int pat,
                             input bit gaps, input int abort_after);
        int fin0, nacc, to;
        bit acc;
        frame_wins = 0;
        fin0 = n_fin;
        nacc = 0;
        @(posedge clk); #1;
        ancho_imagen = 11'(w); alto_imagen = 11'(h); tamano_mascara = 3'(m);
        iniciar = 1'b1;
        @(posedge clk); #1;
        iniciar = 1'b0;
        for (int f = 0; f < h; f++) begin
            for (int c = 0; c < w; c++) begin
                if (abort_after >= 0 && nacc == abort_after) return;
                if (gaps) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
                pixel_valido = 1'b1;
                pixel_entrada = pix(pat, w, f, c);
                to = 0;
                do begin
                    @(negedge clk); #2;
                    acc = read_pixel;
                    if (acc && f >= m - 1 && c >= m - 1)
                        exp_q.push_back(ventana_esperada(pat, w, m, f, c));
                    @(posedge clk); #1;
                    to++;
                end while (!acc && to < 1000);
                pixel_valido = 1'b0;
                if (!acc) begin
                    n_cmp++; n_err++;
                    $display("FAIL accept_timeout: got no read_pixel expected acceptance");
                    return;
                end
                nacc++;
            end
        end
        to = 0;
        while (n_fin == fin0 && to < 2000) begin @(posedge clk); #1; to++; end
        repeat (3) @(posedge clk);
        #1;
        chk("window_count", 200'(frame_wins), 200'((w - m + 1) * (h - m + 1)));
        chk("fin_once", 200'(n_fin - fin0), 200'(1));
        chk("queue_empty", 200'(exp_q.size()), 200'(0));
    endtask

    task automatic bad_config(input int w, input int m, input string name);
        @(posedge clk); #1;
        ancho_imagen = 11'(w); alto_imagen = 11'd8; tamano_mascara = 3'(m);
        iniciar = 1'b1;
        pixel_valido = 1'b1;
        @(posedge clk); #1;
        iniciar = 1'b0;
        chk({name, "_pulse"}, 200'(error_config), 200'(1));
        chk({name, "_ready"}, 200'(read_pixel), 200'(0));
        @(posedge clk); #1;
        chk({name, "_fall"}, 200'(error_config), 200'(0));
        chk({name, "_idle"}, 200'(read_pixel), 200'(0));
        pixel_valido = 1'b0;
    endtask

    initial begin
        int fin_before;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 200'(ventana_valida), 200'(0));
        chk("rst_ready", 200'(read_pixel), 200'(0));
        chk("rst_window", ventana, 200'(0));
        chk("rst_fin", 200'(fin_imagen), 200'(0));
        chk("rst_err", 200'(error_config), 200'(0));
        reset = 1'b0;

        // m=3 8x6 ramp; first window {0,1,2 / 8,9,10 / 16,17,18}
        run_frame(8, 6, 3, 0, 1'b0, -1);
        chk("t1_e0", elem(first_win, 0), 200'(0));
        chk("t1_e2", elem(first_win, 2), 200'(2));
        chk("t1_e6", elem(first_win, 6), 200'(9));
        chk("t1_e12", elem(first_win, 12), 200'(18));
        chk("t1_e3_zero", elem(first_win, 3), 200'(0));
        chk("t1_e15_zero", elem(first_win, 15), 200'(0));

        // m=5 16x16 ramp; window centred at (2,2)
        run_frame(16, 16, 5, 0, 1'b0, -1);
        chk("t2_e12", elem(first_win, 12), 200'(34));
        chk("t2_e24", elem(first_win, 24), 200'(68));
        chk("t2_e4", elem(first_win, 4), 200'(4));

        // m=5 8x8 with a consumer stall on the 4th window
        stall_en = 1'b1;
        run_frame(8, 8, 5, 0, 1'b0, -1);
        chk("t3_stall_done", 200'(stall_en), 200'(0));

        bad_config(8, 4, "err_m4");
        bad_config(2, 3, "err_w2");

        // m=3 32x4 with random input gaps
        run_frame(32, 4, 3, 1, 1'b1, -1);

        // Abort a 10x10 frame at pixel 20 with reset
        fin_before = n_fin;
        run_frame(10, 10, 3, 0, 1'b0, 20);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_valid", 200'(ventana_valida), 200'(0));
        chk("mid_rst_ready", 200'(read_pixel), 200'(0));
        chk("mid_rst_fin", 200'(fin_imagen), 200'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_fin", 200'(n_fin - fin_before), 200'(0));
        run_frame(5, 4, 3, 0, 1'b0, -1);
        chk("t6_e0", elem(first_win, 0), 200'(0));
        chk("t6_e6", elem(first_win, 6), 200'(6));
        chk("t6_e12", elem(first_win, 12), 200'(12));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule
